mult_div_unit: RTL and testbench

Multicycle signed multiply/divide responder that executes the MULT and DIV operations issued by the processor control unit and holds the HI/LO result registers read by MFHI/MFLO. It implements the control unit's start/done handshake: the control unit pulses a start, waits in its MULT/DIV state until done, and branches to its zero-divide exception state when div_zero is flagged. Operands come from the A/B register outputs of the datapath.

---
 rtl/mult_div_unit.sv | 124 ++++++++++++
 tb/tb_mult_div_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply (radix-2 Booth) / divide (restoring) with HI/LO result registers.
// Optional macro DIV_ZERO_TRAP_EN: divide by zero finishes at once with a div_zero pulse and leaves hi/lo unchanged.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [65:0] acc_q;
    logic [31:0] op_q, hi_q, lo_q;
    logic        sign_q_q, sign_r_q, busy_q, done_q;
    logic [31:0] a_mag, b_mag, rem_sh, quo_fix, rem_fix;
    logic [32:0] booth_sum, trial;
    logic [65:0] booth_nxt, div_nxt;

    // Booth upper part carries a guard bit so -2^31 * -2^31 cannot overflow mid-iteration.
    always_comb begin
        a_mag     = a[31] ? -a : a;
        b_mag     = b[31] ? -b : b;
        booth_sum = (acc_q[1:0] == 2'b01) ? acc_q[65:33] + {op_q[31], op_q} :
                    (acc_q[1:0] == 2'b10) ? acc_q[65:33] - {op_q[31], op_q} : acc_q[65:33];
        booth_nxt = $signed({booth_sum, acc_q[32:0]}) >>> 1;
        rem_sh    = acc_q[62:31];
        trial     = {1'b0, rem_sh} - {1'b0, op_q};
        div_nxt   = trial[32] ? {2'b00, rem_sh, acc_q[30:0], 1'b0} : {2'b00, trial[31:0], acc_q[30:0], 1'b1};
        quo_fix   = (op_q == '0) ? 32'hFFFF_FFFF : sign_q_q ? -acc_q[31:0] : acc_q[31:0];
        rem_fix   = sign_r_q ? -acc_q[63:32] : acc_q[63:32];
    end

`ifdef DIV_ZERO_TRAP_EN
    logic div_zero_q;
    always_ff @(posedge clk)
        div_zero_q <= !reset && state_q == IDLE && !mult_start && div_start && b == '0;
    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mult_start) begin
                        state_q <= MUL;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        op_q    <= a;
                        acc_q   <= {33'b0, b, 1'b0};
                    end else if (div_start) begin
`ifdef DIV_ZERO_TRAP_EN
                        if (b == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            state_q  <= DIV;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            op_q     <= b_mag;
                            acc_q    <= {34'b0, a_mag};
                            sign_q_q <= a[31] ^ b[31];
                            sign_r_q <= a[31];
                        end
                    end
                end
                MUL: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd32) begin
                        hi_q    <= acc_q[64:33];
                        lo_q    <= acc_q[32:1];
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        acc_q <= booth_nxt;
                    end
                end
                DIV: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd32) state_q <= FIX;
                    else acc_q <= div_nxt;
                end
                FIX: begin
                    hi_q    <= rem_fix;
                    lo_q    <= quo_fix;
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with a plain-arithmetic reference model.
module tb_mult_div_unit;
    logic        clk = 1'b0, reset = 1'b1, mult_start = 1'b0, div_start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    int          checks = 0, errors = 0, cyc = 0, bcnt = 0;
    logic [31:0] mhi = '0, mlo = '0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          done_cyc;
        int          busy_n;
    } exp_t;
    exp_t sb[$];

    mult_div_unit dut (
        .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
        .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected results come from 64-bit signed arithmetic; SV / and % truncate toward zero.
    task automatic issue(input bit m, input bit d, input logic [31:0] ia, input logic [31:0] ib);
        exp_t   e;
        longint sa, sbv, r;
        sa  = longint'($signed(ia));
        sbv = longint'($signed(ib));
        mult_start = m;
        div_start  = d;
        a = ia;
        b = ib;
        if (m) begin
            r = sa * sbv;
            e.hi = r[63:32]; e.lo = r[31:0]; e.dz = 1'b0;
            e.done_cyc = cyc + 1 + 33; e.busy_n = 33;
        end else if (sbv == 0) begin
`ifdef DIV_ZERO_TRAP_EN
            e.hi = mhi; e.lo = mlo; e.dz = 1'b1;
            e.done_cyc = cyc + 1; e.busy_n = 0;
`else
            e.hi = ia; e.lo = 32'hFFFF_FFFF; e.dz = 1'b0;
            e.done_cyc = cyc + 1 + 34; e.busy_n = 34;
`endif
        end else begin
            r = sa / sbv;
            e.lo = r[31:0];
            r = sa % sbv;
            e.hi = r[31:0]; e.dz = 1'b0;
            e.done_cyc = cyc + 1 + 34; e.busy_n = 34;
        end
        mhi = e.hi;
        mlo = e.lo;
        sb.push_back(e);
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        int s = $urandom_range(0, 5);
        return (s == 0) ? 32'h0 : (s == 1) ? 32'h8000_0000 : (s == 2) ? 32'hFFFF_FFFF :
               (s == 3) ? 32'($urandom_range(0, 15)) : 32'($urandom);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_zero", 32'(div_zero), 32'(e.dz));
                chk("done_cycle", cyc, e.done_cyc);
                chk("busy_cycles", bcnt, e.busy_n);
            end
            bcnt = 0;
        end else begin
            if (div_zero) begin
                checks++;
                errors++;
                $display("FAIL stray_div_zero: got 1 expected 0 (cycle %0d)", cyc);
            end
            bcnt = busy ? bcnt + 1 : 0;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_div_zero", 32'(div_zero), 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        @(negedge clk);

        issue(1, 0, 32'd7, 32'hFFFF_FFFD);          drain();
        issue(1, 0, 32'h8000_0000, 32'h8000_0000);  drain();
        chk("min_sq_hi", hi, 32'h4000_0000);
        issue(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  drain();
        issue(0, 1, 32'hFFFF_FFF9, 32'd2);          drain();
        issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);  drain();
        chk("ovf_lo", lo, 32'h8000_0000);
        issue(0, 1, 32'd5, 32'd0);                  drain();
        issue(1, 1, 32'd6, 32'd4);                  drain();
        chk("both_lo", lo, 32'd24);

        issue(1, 0, 32'd100, 32'd200);
        repeat (5) @(negedge clk);
        div_start = 1'b1; a = 32'd9; b = 32'd3;
        @(negedge clk);
        div_start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        issue(1, 0, 32'h6666_6666, 32'h2AAA_AAAB);  drain();
        chk("pre_hi", hi, 32'h1111_1111);
        chk("pre_lo", lo, 32'h2222_2222);
        issue(1, 0, 32'd3, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        @(negedge clk);
        issue(1, 0, 32'd3, 32'd3);                  drain();
        chk("after_abort_lo", lo, 32'd9);

        for (int i = 0; i < 24; i++) begin
            bit m = ($urandom_range(0, 1) == 1);
            issue(m, !m, pick(), pick());
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
